// File: rtl/led_rate_mon.sv
// Blink-rate monitor: measures the half-period of an asynchronous LED line and recovers the divider.
// Optional glitch filter after the synchroniser is enabled with LED_RATE_MON_FILTER_EN.
module led_rate_mon #(
  parameter logic [27:0] CNT_1S   = 28'h5F5E100,
  parameter logic [27:0] TIMEOUT  = 28'hBEBC200,
  parameter int          FILT_LEN = 4
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic        led_i,
  output logic [27:0] period_o,
  output logic [4:0]  div_o,
  output logic        valid_o,
  output logic        stall_o,
  output logic        ovr_o
);

  typedef enum logic [1:0] {IDLE, MEAS, DIV} state_t;

  state_t      state, state_nx;
  logic        sync1, sync2, lvl;
  logic        edge_acc;
  logic [27:0] cnt;
  logic [27:0] rem, quo, dvs;
  logic [4:0]  bit_cnt;
  logic        to_idle;
  logic [28:0] shifted, diff;
  logic        ge, div_done, sat, tmo;
  logic [27:0] quo_nx;

`ifdef LED_RATE_MON_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic [FW-1:0] fcnt;

  // A new level is taken only once it has differed from the accepted level long enough.
  assign edge_acc = (sync2 != lvl) && (fcnt == FW'(FILT_LEN));

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl   <= 1'b0;
      fcnt  <= '0;
    end else begin
      sync1 <= led_i;
      sync2 <= sync1;
      if (sync2 == lvl) begin
        fcnt <= '0;
      end else if (edge_acc) begin
        lvl  <= sync2;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end
`else
  logic unused_filt;
  assign unused_filt = |FILT_LEN;
  assign edge_acc    = (sync2 != lvl);

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      lvl   <= 1'b0;
    end else begin
      sync1 <= led_i;
      sync2 <= sync1;
      lvl   <= sync2;
    end
  end
`endif

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (edge_acc) begin
      cnt <= '0;
    end else if (cnt != 28'hFFFFFFF) begin
      cnt <= cnt + 28'd1;
    end
  end

  // Restoring divide step; the borrow bit of the trial subtraction is the inverted quotient bit.
  assign shifted  = {rem, quo[27]};
  assign diff     = shifted - {1'b0, dvs};
  assign ge       = ~diff[28];
  assign quo_nx   = {quo[26:0], ge};
  assign div_done = (state == DIV) && (bit_cnt == 5'd27);
  assign sat      = (quo_nx[27:5] != 23'd0) || (dvs == 28'd0);
  assign tmo      = (cnt == TIMEOUT) && !edge_acc;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (edge_acc) state_nx = MEAS;
      MEAS: begin
        if (edge_acc) state_nx = DIV;
        else if (tmo) state_nx = IDLE;
      end
      DIV:  if (div_done) state_nx = (to_idle || tmo) ? IDLE : MEAS;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      period_o <= '0;
      div_o    <= '0;
      valid_o  <= 1'b0;
      stall_o  <= 1'b0;
      ovr_o    <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      bit_cnt  <= '0;
      to_idle  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: if (edge_acc) stall_o <= 1'b0;
        MEAS: begin
          if (edge_acc) begin
            period_o <= cnt + 28'd1;
            dvs      <= cnt;
            rem      <= '0;
            quo      <= CNT_1S;
            bit_cnt  <= '0;
            to_idle  <= 1'b0;
          end else if (tmo) begin
            stall_o <= 1'b1;
          end
        end
        DIV: begin
          rem     <= ge ? diff[27:0] : shifted[27:0];
          quo     <= quo_nx;
          bit_cnt <= bit_cnt + 5'd1;
          if (edge_acc) begin
            ovr_o <= 1'b1;
          end else if (tmo) begin
            stall_o <= 1'b1;
            to_idle <= 1'b1;
          end
          if (div_done) begin
            div_o   <= sat ? 5'd31 : quo_nx[4:0];
            valid_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
